// File: rtl/sub_serial_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// The requester drives start and the operands; the subtractor drives status and result.
interface sub_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             is_overflowed;
  logic             zero;

  modport master (
    output start, inA, inB,
    input  busy, done, diff, borrow, is_overflowed, zero
  );

  modport slave (
    input  start, inA, inB,
    output busy, done, diff, borrow, is_overflowed, zero
  );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: computes inA - inB as A + ~B + 1, one bit per clock,
// LSB first. Operands are latched on the accepting edge; partial sums build up
// in a shadow register and are published, with flags, only when the MSB step
// completes. WIDTH is meant to stay within 2..16.
module sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  sub_serial_if.slave  bus
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MSB  = WIDTH - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One full-adder step; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [1:0]       step_s;
  logic [WIDTH-1:0] shadow_upd_s;

  // State, operand, shadow and output registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      idx_q    <= {IDXW{1'b0}};
      shadow_q <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state logic: accept in IDLE, one adder step per SHIFT edge, publish on the last step.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    step_s              = full_add(a_q[idx_q], ~b_q[idx_q], carry_q);
    shadow_upd_s        = shadow_q;
    shadow_upd_s[idx_q] = step_s[0];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.inA;
          b_d      = bus.inB;
          carry_d  = 1'b1;
          idx_d    = {IDXW{1'b0}};
          shadow_d = {WIDTH{1'b0}};
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        shadow_d = shadow_upd_s;
        carry_d  = step_s[1];
        if (idx_q == LAST_IDX) begin
          // Final step: result and flags become visible together with done.
          idx_d    = {IDXW{1'b0}};
          done_d   = 1'b1;
          diff_d   = shadow_upd_s;
          borrow_d = ~step_s[1];
          ovf_d    = (a_q[MSB] ^ b_q[MSB]) & (shadow_upd_s[MSB] ^ a_q[MSB]);
          zero_d   = ~(|shadow_upd_s);
          state_d  = DONE;
        end else begin
          idx_d    = idx_q + IDXW'(1);
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.diff          = diff_q;
  assign bus.borrow        = borrow_q;
  assign bus.is_overflowed = ovf_q;
  assign bus.zero          = zero_q;

endmodule
